up_down_counter_param: RTL

- Parametrised successor to the team's 8-bit load/enable/up-down counter.
- Adds the following:
  - configurable width
  - programmable step size
  - programmable upper limit
  - run-time wrap/saturate mode
  - registered terminal-count output
- Drop-in for the counter slot behind the counter interface; the existing signal names are kept.

---
 rtl/up_down_counter_param.sv | 131 +++++++++++++
 1 files changed

// File: rtl/up_down_counter_param.sv
// Parametrised load/enable up-down counter with step, inclusive limit, wrap/saturate mode and registered tc.
// Latency: data_out and tc update one clock after the sampled inputs; no backpressure (accepts every cycle).
// Optional sticky overflow/underflow flags are built in when COUNTER_STICKY_FLAGS_EN is defined.
module up_down_counter_param #(
    parameter int               WIDTH     = 8,
    parameter int               STEP_W    = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  data_in,
    input  logic              load,
    input  logic              enable,
    input  logic              up_down,
    input  logic [STEP_W-1:0] step,
    input  logic [WIDTH-1:0]  limit,
    input  logic              mode,
    output logic [WIDTH-1:0]  data_out,
    output logic              tc
`ifdef COUNTER_STICKY_FLAGS_EN
   ,input  logic              clr_flags,
    output logic              ovf_sticky,
    output logic              unf_sticky
`endif
);

    localparam int EW = ((STEP_W > WIDTH) ? STEP_W : WIDTH) + 1;
    localparam logic [WIDTH:0] ONE_X = {{WIDTH{1'b0}}, 1'b1};

    logic [WIDTH-1:0] data_q, data_d;
    logic             tc_q, tc_d;
    logic             up_evt, dn_evt, rec_evt;

    logic [EW-1:0]    step_e, lim_e, s_e;
    logic [WIDTH:0]   s_x, cur_x, lim_x, sum_x, diff_x, wrap_up_x, wrap_dn_x;
    logic             unused_bits;

    // Effective step is clamped to limit, so it always fits in WIDTH+1 bits.
    assign step_e    = {{(EW-STEP_W){1'b0}}, step};
    assign lim_e     = {{(EW-WIDTH){1'b0}}, limit};
    assign s_e       = (step_e < lim_e) ? step_e : lim_e;
    assign s_x       = s_e[WIDTH:0];
    assign cur_x     = {1'b0, data_q};
    assign lim_x     = {1'b0, limit};
    assign sum_x     = cur_x + s_x;
    assign diff_x    = cur_x - s_x;
    assign wrap_up_x = sum_x - lim_x - ONE_X;
    assign wrap_dn_x = cur_x + lim_x + ONE_X - s_x;

    assign unused_bits = ^{s_e, diff_x[WIDTH], wrap_up_x[WIDTH], wrap_dn_x[WIDTH]};

    always_comb begin
        data_d  = data_q;
        tc_d    = 1'b0;
        up_evt  = 1'b0;
        dn_evt  = 1'b0;
        rec_evt = 1'b0;
        if (load) begin
            data_d = (data_in > limit) ? limit : data_in;
        end else if (enable && (s_x != '0)) begin
            if (data_q > limit) begin
                // limit was lowered under the count: snap back into range regardless of direction
                rec_evt = 1'b1;
                tc_d    = 1'b1;
                data_d  = mode ? limit : '0;
            end else if (up_down) begin
                if (sum_x <= lim_x) begin
                    data_d = sum_x[WIDTH-1:0];
                end else begin
                    up_evt = 1'b1;
                    tc_d   = 1'b1;
                    data_d = mode ? limit : wrap_up_x[WIDTH-1:0];
                end
            end else begin
                if (cur_x >= s_x) begin
                    data_d = diff_x[WIDTH-1:0];
                end else begin
                    dn_evt = 1'b1;
                    tc_d   = 1'b1;
                    data_d = mode ? '0 : wrap_dn_x[WIDTH-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_q <= RESET_VAL;
            tc_q   <= 1'b0;
        end else begin
            data_q <= data_d;
            tc_q   <= tc_d;
        end
    end

    assign data_out = data_q;
    assign tc       = tc_q;

`ifdef COUNTER_STICKY_FLAGS_EN
    logic ovf_q, ovf_d, unf_q, unf_d;

    // A new boundary event in the same cycle beats the clear request.
    always_comb begin
        ovf_d = ovf_q;
        unf_d = unf_q;
        if (clr_flags) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end
        if (up_evt || rec_evt) ovf_d = 1'b1;
        if (dn_evt)            unf_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign ovf_sticky = ovf_q;
    assign unf_sticky = unf_q;
`else
    logic unused_evt;
    assign unused_evt = ^{up_evt, dn_evt, rec_evt};
`endif

endmodule
